// File: rtl/phase_request_scheduler.sv
// -----------------------------------------------------------------------------
// phase_request_scheduler
//
// Shares one intersection between three signal phases:
//   P0 = E/W through, P1 = N left, P2 = E left.
// Sensor requests are latched as sticky pending bits. Each handover runs
// GREEN -> YELLOW -> ALL_RED -> next GREEN. The next phase is chosen
// round-robin, starting from the one after the current phase. All timing is
// counted in timebase ticks.
//
// Ports
//   clk          in   1    system clock, rising edge
//   sys_reset_n  in   1    asynchronous active-low reset
//   tick         in   1    one-clk timebase strobe
//   req_w/req_e  in   1    W/E through sensors (P0)
//   req_nl       in   1    N left sensor (P1)
//   req_el       in   1    E left sensor (P2)
//   phase        out  2    phase owning the intersection (0..2)
//   lamp_p0..p2  out  2    lamp per phase: 00 green, 01 yellow, 10 red
//   pending      out  3    latched requests, bit i = phase i waiting
//   timer        out  CW   ticks elapsed in the current state (saturating)
// -----------------------------------------------------------------------------
module phase_request_scheduler #(
    parameter int CW        = 4,
    parameter int MIN_GREEN = 3,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic          clk,
    input  logic          sys_reset_n,
    input  logic          tick,
    input  logic          req_w,
    input  logic          req_e,
    input  logic          req_nl,
    input  logic          req_el,
    output logic [1:0]    phase,
    output logic [1:0]    lamp_p0,
    output logic [1:0]    lamp_p1,
    output logic [1:0]    lamp_p2,
    output logic [2:0]    pending,
    output logic [CW-1:0] timer
);

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2
    } state_e;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    localparam logic [CW-1:0] MIN_G     = CW'(MIN_GREEN);
    localparam logic [CW-1:0] MAX_G     = CW'(MAX_GREEN);
    localparam logic [CW-1:0] YEL_T     = CW'(YELLOW_T);
    localparam logic [CW-1:0] AR_T      = CW'(ALLRED_T);
    localparam logic [CW-1:0] TIMER_MAX = '1;

    state_e          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      pending_q, pending_d;
    logic [CW-1:0]   timer_q, timer_d;

    logic [2:0]      sensor;
    logic [2:0]      phase_onehot;
    logic [2:0]      others;
    logic [1:0]      phase_p1, phase_p2;
    logic [2:0][1:0] lamps;

    function automatic logic [1:0] next_mod3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign sensor       = {req_el, req_nl, req_w | req_e};
    assign phase_onehot = 3'b001 << phase_q;
    assign others       = pending_q & ~phase_onehot;
    assign phase_p1     = next_mod3(phase_q);
    assign phase_p2     = next_mod3(phase_p1);

    // Next-state / next-phase decision, always based on the registered timer.
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_GREEN: begin
                // Yield only when someone else waits, and either green has run
                // its maximum or the minimum is met and our own sensor is idle.
                if (others != 3'b000 &&
                    (timer_q >= MAX_G || (timer_q >= MIN_G && !sensor[phase_q]))) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timer_q >= YEL_T) state_d = ST_ALL_RED;
            end
            ST_ALL_RED: begin
                if (timer_q >= AR_T) begin
                    state_d = ST_GREEN;
                    if (pending_q[phase_p1])      phase_d = phase_p1;
                    else if (pending_q[phase_p2]) phase_d = phase_p2;
                    else                          phase_d = phase_p1;
                end
            end
            default: state_d = ST_GREEN;
        endcase
    end

    // Sticky requests. A phase that is already green does not latch its own
    // sensor; the phase about to enter green has its bit cleared, and that
    // clear overrides a set on the same edge.
    always_comb begin
        pending_d = pending_q | (sensor & ~((state_q == ST_GREEN) ? phase_onehot : 3'b000));
        if (state_q == ST_ALL_RED && state_d == ST_GREEN) begin
            pending_d = pending_d & ~(3'b001 << phase_d);
        end
    end

    // A tick landing on a transition edge is dropped: the clear takes priority.
    always_comb begin
        if (state_d != state_q)                  timer_d = '0;
        else if (tick && timer_q != TIMER_MAX)   timer_d = timer_q + CW'(1);
        else                                     timer_d = timer_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q   <= ST_GREEN;
            phase_q   <= 2'd0;
            pending_q <= 3'b000;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

    // Only the active phase can show a non-red aspect.
    always_comb begin
        lamps = {3{LAMP_RED}};
        unique case (state_q)
            ST_GREEN:  lamps[phase_q] = LAMP_GREEN;
            ST_YELLOW: lamps[phase_q] = LAMP_YELLOW;
            default:   lamps[phase_q] = LAMP_RED;
        endcase
    end

    assign phase   = phase_q;
    assign lamp_p0 = lamps[0];
    assign lamp_p1 = lamps[1];
    assign lamp_p2 = lamps[2];
    assign pending = pending_q;
    assign timer   = timer_q;

endmodule

// File: tb/tb_phase_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_phase_request_scheduler
//
// Directed bench for phase_request_scheduler with default parameters. Each
// step pushes the expected output snapshot to a scoreboard queue as it drives
// stimulus; after the clock edge the snapshot is popped and compared.
// -----------------------------------------------------------------------------
module tb_phase_request_scheduler;

    localparam int CW = 4;

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] RED = 2'b10;

    logic          clk         = 1'b0;
    logic          sys_reset_n = 1'b0;
    logic          tick        = 1'b0;
    logic          req_w       = 1'b0;
    logic          req_e       = 1'b0;
    logic          req_nl      = 1'b0;
    logic          req_el      = 1'b0;
    logic [1:0]    phase;
    logic [1:0]    lamp_p0, lamp_p1, lamp_p2;
    logic [2:0]    pending;
    logic [CW-1:0] timer;

    phase_request_scheduler #(
        .CW(CW), .MIN_GREEN(3), .MAX_GREEN(10), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .sys_reset_n(sys_reset_n), .tick(tick),
        .req_w(req_w), .req_e(req_e), .req_nl(req_nl), .req_el(req_el),
        .phase(phase), .lamp_p0(lamp_p0), .lamp_p1(lamp_p1), .lamp_p2(lamp_p2),
        .pending(pending), .timer(timer)
    );

    always #5 clk = ~clk;

    // Snapshot: {phase, lamp_p2, lamp_p1, lamp_p0, pending, timer}
    typedef struct {
        string       tag;
        logic [14:0] vec;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic logic [14:0] pack_exp(input logic [1:0] ph, input logic [1:0] col,
                                             input logic [2:0] pend, input int tmr);
        logic [1:0] l [3];
        for (int i = 0; i < 3; i++) l[i] = (int'(ph) == i) ? col : RED;
        return {ph, l[2], l[1], l[0], pend, CW'(tmr)};
    endfunction

    task automatic push(input string tag, input logic [1:0] ph, input logic [1:0] col,
                        input logic [2:0] pend, input int tmr);
        exp_t e;
        e.tag = tag;
        e.vec = pack_exp(ph, col, pend, tmr);
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t        e;
        logic [14:0] obs;
        e   = sb.pop_front();
        obs = {phase, lamp_p2, lamp_p1, lamp_p0, pending, timer};
        compared++;
        assert (obs === e.vec) else begin
            mismatched++;
            $error("FAIL %s: observed ph=%0d lamps(p2,p1,p0)=%b,%b,%b pend=%b tmr=%0d; expected ph=%0d lamps=%b,%b,%b pend=%b tmr=%0d",
                   e.tag, obs[14:13], obs[12:11], obs[10:9], obs[8:7], obs[6:4], obs[3:0],
                   e.vec[14:13], e.vec[12:11], e.vec[10:9], e.vec[8:7], e.vec[6:4], e.vec[3:0]);
        end
    endtask

    // One clock cycle with tick = t, checked against the expected snapshot.
    task automatic cyc(input logic t, input string tag, input logic [1:0] ph,
                       input logic [1:0] col, input logic [2:0] pend, input int tmr);
        tick = t;
        push(tag, ph, col, pend, tmr);
        @(posedge clk);
        #1;
        tick = 1'b0;
        pop_cmp();
    endtask

    // Full handover starting on the edge where GREEN yields; pending is
    // constant through yellow/all-red and becomes pend_to at the grant.
    task automatic handover(input string tag, input logic [1:0] from, input logic [2:0] pend,
                            input logic [1:0] to, input logic [2:0] pend_to);
        cyc(1'b0, {tag, "_yield"},  from, YEL, pend, 0);
        cyc(1'b1, {tag, "_y1"},     from, YEL, pend, 1);
        cyc(1'b1, {tag, "_y2"},     from, YEL, pend, 2);
        cyc(1'b0, {tag, "_allred"}, from, RED, pend, 0);
        cyc(1'b1, {tag, "_ar1"},    from, RED, pend, 1);
        cyc(1'b0, {tag, "_grant"},  to,   GRN, pend_to, 0);
    endtask

    // Called 1 time unit after a rising edge: reset is asserted and released
    // between edges.
    task automatic do_reset(input string tag);
        {req_w, req_e, req_nl, req_el, tick} = '0;
        sys_reset_n = 1'b0;
        #2;
        push(tag, 2'd0, GRN, 3'b000, 0);
        pop_cmp();
        #2;
        sys_reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset values, then rest in P0 green with its own sensor held.
        #12;
        push("reset_init", 2'd0, GRN, 3'b000, 0);
        pop_cmp();
        sys_reset_n = 1'b1;
        @(posedge clk);
        #1;
        req_e = 1'b1;
        for (int k = 1; k <= 20; k++) cyc(1'b1, "rest", 2'd0, GRN, 3'b000, (k > 15) ? 15 : k);

        // 2: min green, single-cycle request for P2 at timer=1.
        do_reset("reset_mg");
        cyc(1'b1, "mg_t1", 2'd0, GRN, 3'b000, 1);
        req_el = 1'b1;
        cyc(1'b0, "mg_pulse", 2'd0, GRN, 3'b100, 1);
        req_el = 1'b0;
        cyc(1'b1, "mg_t2", 2'd0, GRN, 3'b100, 2);
        cyc(1'b1, "mg_t3", 2'd0, GRN, 3'b100, 3);
        handover("mg", 2'd0, 3'b100, 2'd2, 3'b000);

        // 3: max green, P0 sensor held, P1 pulsed at timer=0.
        do_reset("reset_mx");
        req_w  = 1'b1;
        req_nl = 1'b1;
        cyc(1'b0, "mx_pulse", 2'd0, GRN, 3'b010, 0);
        req_nl = 1'b0;
        for (int k = 1; k <= 10; k++) cyc(1'b1, "mx_hold", 2'd0, GRN, 3'b010, k);
        cyc(1'b0, "mx_yield",  2'd0, YEL, 3'b010, 0);
        cyc(1'b1, "mx_y1",     2'd0, YEL, 3'b011, 1);
        cyc(1'b1, "mx_y2",     2'd0, YEL, 3'b011, 2);
        cyc(1'b0, "mx_allred", 2'd0, RED, 3'b011, 0);
        cyc(1'b1, "mx_ar1",    2'd0, RED, 3'b011, 1);
        cyc(1'b0, "mx_grant",  2'd1, GRN, 3'b001, 0);

        // 4: round robin from P1 with pending 101: P2 next, then P0.
        req_w  = 1'b0;
        req_nl = 1'b1;
        req_el = 1'b1;
        cyc(1'b0, "rr_load", 2'd1, GRN, 3'b101, 0);
        req_el = 1'b0;
        for (int k = 1; k <= 4; k++) cyc(1'b1, "rr_hold", 2'd1, GRN, 3'b101, k);
        req_nl = 1'b0;
        handover("rr1", 2'd1, 3'b101, 2'd2, 3'b001);
        for (int k = 1; k <= 3; k++) cyc(1'b1, "rr_p2", 2'd2, GRN, 3'b001, k);
        handover("rr2", 2'd2, 3'b001, 2'd0, 3'b000);

        // 5: P2 sensor held through the grant edge; clear wins, stays clear.
        req_el = 1'b1;
        cyc(1'b0, "sg_set", 2'd0, GRN, 3'b100, 0);
        for (int k = 1; k <= 3; k++) cyc(1'b1, "sg_p0", 2'd0, GRN, 3'b100, k);
        handover("sg", 2'd0, 3'b100, 2'd2, 3'b000);
        cyc(1'b0, "sg_hold0", 2'd2, GRN, 3'b000, 0);
        cyc(1'b1, "sg_hold1", 2'd2, GRN, 3'b000, 1);
        cyc(1'b0, "sg_hold2", 2'd2, GRN, 3'b000, 1);
        req_el = 1'b0;

        // 6: asynchronous reset mid-yellow, then normal sequencing.
        req_nl = 1'b1;
        cyc(1'b0, "ar_pulse", 2'd2, GRN, 3'b010, 1);
        req_nl = 1'b0;
        cyc(1'b1, "ar_t2", 2'd2, GRN, 3'b010, 2);
        cyc(1'b1, "ar_t3", 2'd2, GRN, 3'b010, 3);
        cyc(1'b0, "ar_yield", 2'd2, YEL, 3'b010, 0);
        cyc(1'b1, "ar_y1",    2'd2, YEL, 3'b010, 1);
        #2;
        sys_reset_n = 1'b0;
        #1;
        push("ar_async", 2'd0, GRN, 3'b000, 0);
        pop_cmp();
        @(posedge clk);
        #1;
        push("ar_held", 2'd0, GRN, 3'b000, 0);
        pop_cmp();
        sys_reset_n = 1'b1;
        req_nl = 1'b1;
        cyc(1'b0, "ar_resume", 2'd0, GRN, 3'b010, 0);
        req_nl = 1'b0;
        for (int k = 1; k <= 3; k++) cyc(1'b1, "ar_p0", 2'd0, GRN, 3'b010, k);
        handover("ar_rr", 2'd0, 3'b010, 2'd1, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
